// File: rtl/vram_port_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_if
// Purpose  : Bundles the render, CPU and VRAM-array signals that surround the
//            VRAM port controller. slave = controller view, master = the
//            surrounding system (render pipe, CPU register block, VRAM).
// Revision : 1.0 - initial release
// ============================================================================
interface vram_port_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // render fetch channel
    logic          render_req;
    logic [AW-1:0] render_addr;
    logic          render_valid;
    logic [DW-1:0] render_data;
    // CPU register channel (MAWR / MARR / VRR)
    logic          cpu_set_mawr;
    logic          cpu_set_marr;
    logic [AW-1:0] cpu_addr;
    logic          cpu_wr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rd_ack;
    logic [1:0]    inc_sel;
    logic [DW-1:0] vrr;
    logic          vrr_valid;
    logic          cpu_busy;
    logic          wr_overrun;
    logic [AW-1:0] mawr;
    logic [AW-1:0] marr;
    // VRAM array port
    logic [AW-1:0] MA;
    logic          re;
    logic          we;
    logic [DW-1:0] MD_in;
    logic [DW-1:0] MD_out;

    modport slave (
        input  render_req, render_addr,
        input  cpu_set_mawr, cpu_set_marr, cpu_addr, cpu_wr, cpu_wdata,
        input  cpu_rd_ack, inc_sel,
        input  MD_out,
        output render_valid, render_data,
        output vrr, vrr_valid, cpu_busy, wr_overrun, mawr, marr,
        output MA, re, we, MD_in
    );

    modport master (
        output render_req, render_addr,
        output cpu_set_mawr, cpu_set_marr, cpu_addr, cpu_wr, cpu_wdata,
        output cpu_rd_ack, inc_sel,
        output MD_out,
        input  render_valid, render_data,
        input  vrr, vrr_valid, cpu_busy, wr_overrun, mawr, marr,
        input  MA, re, we, MD_in
    );
endinterface
`default_nettype wire

// File: rtl/vram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vram_port_ctrl
// Purpose  : Owns the single VRAM port. Render fetches always win; CPU writes
//            go through a one-deep write buffer and CPU reads through a
//            one-word prefetch (VRR), with a programmable auto-increment.
// Revision : 1.0 - initial release
// ============================================================================
module vram_port_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  wire logic   clock,
    input  wire logic   reset,
    vram_port_if.slave  bus
);

    // grants for the current cycle (mutually exclusive)
    logic          render_grant;
    logic          write_grant;
    logic          read_grant;
    logic [AW-1:0] inc;

    // architectural state
    logic [AW-1:0] mawr_reg;
    logic [AW-1:0] marr_reg;
    logic [DW-1:0] wbuf;
    logic [DW-1:0] vrr_reg;
    logic          vrr_valid_reg;
    logic          pend_w;
    logic          pend_r;
    logic          rd_inflight;
    logic          discard;
    logic          overrun;
    logic          render_valid_reg;

    // the write buffer frees on a write grant, so a same-cycle cpu_wr fits
    logic          wr_accept;

    // fixed-priority arbitration: render, then write, then read
    always_comb begin
        render_grant = bus.render_req;
        write_grant  = !bus.render_req && pend_w;
        read_grant   = !bus.render_req && !pend_w && pend_r && !rd_inflight;
        wr_accept    = bus.cpu_wr && (!pend_w || write_grant);
    end

    // auto-increment step, sampled in the grant cycle
    always_comb begin
        case (bus.inc_sel)
            2'b00:   inc = AW'(1);
            2'b01:   inc = AW'(32);
            2'b10:   inc = AW'(64);
            default: inc = AW'(128);
        endcase
    end

    // VRAM port drive; the array registers these, so data returns next cycle
    always_comb begin
        bus.MA    = '0;
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.MD_in = '0;
        if (render_grant) begin
            bus.MA = bus.render_addr;
            bus.re = 1'b1;
        end else if (write_grant) begin
            bus.MA    = mawr_reg;
            bus.we    = 1'b1;
            bus.MD_in = wbuf;
        end else if (read_grant) begin
            bus.MA = marr_reg;
            bus.re = 1'b1;
        end
    end

    // write buffer, MAWR and overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbuf     <= '0;
            pend_w   <= 1'b0;
            mawr_reg <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wbuf   <= bus.cpu_wdata;
                pend_w <= 1'b1;
            end else if (write_grant) begin
                pend_w <= 1'b0;
            end
            if (bus.cpu_wr && !wr_accept) begin
                overrun <= 1'b1;
            end
            // a reload overrides the post-write increment
            if (bus.cpu_set_mawr) begin
                mawr_reg <= bus.cpu_addr;
            end else if (write_grant) begin
                mawr_reg <= mawr_reg + inc;
            end
        end
    end

    // read prefetch, MARR, VRR and stale-return discard
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            marr_reg      <= '0;
            pend_r        <= 1'b0;
            rd_inflight   <= 1'b0;
            discard       <= 1'b0;
            vrr_reg       <= '0;
            vrr_valid_reg <= 1'b0;
        end else begin
            rd_inflight <= read_grant;
            // a reload racing a read grant makes that grant's return stale
            discard     <= read_grant && bus.cpu_set_marr;

            if (bus.cpu_set_marr) begin
                marr_reg <= bus.cpu_addr;
            end else if (read_grant) begin
                marr_reg <= marr_reg + inc;
            end

            if (bus.cpu_set_marr || bus.cpu_rd_ack) begin
                pend_r <= 1'b1;
            end else if (read_grant) begin
                pend_r <= 1'b0;
            end

            // returning word is dropped if stale or if MARR is reloaded now
            if (rd_inflight && !discard && !bus.cpu_set_marr) begin
                vrr_reg <= bus.MD_out;
            end

            if (bus.cpu_set_marr || bus.cpu_rd_ack) begin
                vrr_valid_reg <= 1'b0;
            end else if (rd_inflight && !discard) begin
                vrr_valid_reg <= 1'b1;
            end
        end
    end

    // render data qualifier, one cycle behind the grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            render_valid_reg <= 1'b0;
        end else begin
            render_valid_reg <= render_grant;
        end
    end

    // output mapping
    always_comb begin
        bus.render_valid = render_valid_reg;
        bus.render_data  = bus.MD_out;
        bus.vrr          = vrr_reg;
        bus.vrr_valid    = vrr_valid_reg;
        bus.cpu_busy     = pend_w;
        bus.wr_overrun   = overrun;
        bus.mawr         = mawr_reg;
        bus.marr         = marr_reg;
    end

endmodule
`default_nettype wire
